// File: rtl/ef_sram_1024x32_bist.sv
`default_nettype none
// ============================================================================
// Module   : ef_sram_1024x32_bist
// Purpose  : March C- built-in self-test engine for a single-port SRAM.
//            Runs E0..E5, compares each read one cycle after it is issued,
//            and reports the address and element of the first mismatch.
// Revision : 1.0  initial release
// ============================================================================
module ef_sram_1024x32_bist #(
    parameter int NB = 32,
    parameter int NA = 10,
    parameter int NW = 1024
) (
    input  logic          CLKin,
    input  logic          RST,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic          FAIL,
    output logic [NA-1:0] FAIL_ADDR,
    output logic [2:0]    FAIL_ELEM,
    output logic [NA-1:0] AD,
    output logic [NB-1:0] DI,
    output logic [NB-1:0] BEN,
    output logic          EN,
    output logic          R_WB,
    input  logic [NB-1:0] DO
);

    localparam logic [NA-1:0] C_LAST = NA'(NW - 1);
    localparam logic [NA-1:0] C_ONE  = NA'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    elem_q, elem_d;
    logic [NA-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;       // 0 = read slot, 1 = write slot (E1-E4)
    logic          rd_pend_q, rd_pend_d;   // a read was issued last cycle
    logic          exp_q, exp_d;           // background expected from that read
    logic [NA-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]    cmp_elem_q, cmp_elem_d;
    logic          fail_q, fail_d;
    logic [NA-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]    fail_elem_q, fail_elem_d;

    logic w_is_read;
    logic w_down;
    logic w_last;
    logic w_mismatch;

    assign w_is_read  = (elem_q == 3'd5) || ((elem_q != 3'd0) && !phase_q);
    assign w_down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign w_last     = w_down ? (addr_q == '0) : (addr_q == C_LAST);
    assign w_mismatch = rd_pend_q && (DO != {NB{exp_q}});

    assign BUSY      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign DONE      = (state_q == S_END);
    assign FAIL      = fail_q;
    assign FAIL_ADDR = fail_addr_q;
    assign FAIL_ELEM = fail_elem_q;

    // State and datapath registers; reset returns the engine to a quiet idle.
    always_ff @(posedge CLKin) begin
        if (RST) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            exp_q       <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            rd_pend_q   <= rd_pend_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    // Next-state, March sequencing, SRAM bus drive and read-compare.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        rd_pend_d   = 1'b0;
        exp_d       = exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        EN          = 1'b0;
        R_WB        = 1'b1;
        AD          = '0;
        DI          = '0;
        BEN         = '0;

        case (state_q)
            S_IDLE, S_END: begin
                if (START) begin
                    state_d     = S_RUN;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                end
            end

            S_RUN: begin
                EN   = 1'b1;
                AD   = addr_q;
                BEN  = {NB{1'b1}};
                R_WB = w_is_read;
                // E1 and E3 write ones; E0, E2, E4 write zeros.
                if (!w_is_read && ((elem_q == 3'd1) || (elem_q == 3'd3)))
                    DI = {NB{1'b1}};

                if (w_is_read) begin
                    rd_pend_d  = 1'b1;
                    exp_d      = (elem_q == 3'd2) || (elem_q == 3'd4);
                    cmp_addr_d = addr_q;
                    cmp_elem_d = elem_q;
                end

                // Read slot of a read-write pair just advances to the write.
                if ((elem_q != 3'd0) && (elem_q != 3'd5) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!w_last) begin
                        addr_d = w_down ? (addr_q - C_ONE) : (addr_q + C_ONE);
                    end else begin
                        case (elem_q)
                            3'd0:    begin elem_d = 3'd1; addr_d = '0;     end
                            3'd1:    begin elem_d = 3'd2; addr_d = '0;     end
                            3'd2:    begin elem_d = 3'd3; addr_d = C_LAST; end
                            3'd3:    begin elem_d = 3'd4; addr_d = C_LAST; end
                            3'd4:    begin elem_d = 3'd5; addr_d = '0;     end
                            default: state_d = S_DRAIN;
                        endcase
                    end
                end

                // First mismatch aborts; this cycle's access still goes out.
                if (w_mismatch) begin
                    state_d     = S_END;
                    rd_pend_d   = 1'b0;
                    fail_d      = 1'b1;
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                end
            end

            S_DRAIN: begin
                state_d = S_END;
                if (w_mismatch) begin
                    fail_d      = 1'b1;
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ef_sram_1024x32_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ef_sram_1024x32_bist
// Purpose  : Directed bench for the March C- engine with a behavioural SRAM
//            that can inject a stuck-at-1 bit or an address coupling fault.
// Revision : 1.0  initial release
// ============================================================================
module tb_ef_sram_1024x32_bist;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic        busy, done, fail, en, r_wb;
    logic [9:0]  fail_addr, ad;
    logic [2:0]  fail_elem;
    logic [31:0] di, ben, dout;
    logic        busy4, done4, fail4, en4, r_wb4;
    logic [1:0]  fail_addr4, ad4;
    logic [2:0]  fail_elem4;
    logic [31:0] di4, ben4, dout4;

    logic [31:0] mem  [0:1023];
    logic [31:0] mem4 [0:3];
    logic [1:0]  fault_mode;   // 0 none, 1 stuck-at-1 bit5 @0x2A5, 2 coupling 0x001->0x000

    int total = 0;
    int bad   = 0;

    logic        tr_rw [0:63];
    logic [1:0]  tr_ad [0:63];
    logic [31:0] tr_di [0:63];
    logic        ex_rw [0:63];
    logic [1:0]  ex_ad [0:63];
    logic [31:0] ex_di [0:63];

    ef_sram_1024x32_bist #(.NB(32), .NA(10), .NW(1024)) dut (
        .CLKin(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done),
        .FAIL(fail), .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem),
        .AD(ad), .DI(di), .BEN(ben), .EN(en), .R_WB(r_wb), .DO(dout)
    );

    ef_sram_1024x32_bist #(.NB(32), .NA(2), .NW(4)) dut4 (
        .CLKin(clk), .RST(rst), .START(start4), .BUSY(busy4), .DONE(done4),
        .FAIL(fail4), .FAIL_ADDR(fail_addr4), .FAIL_ELEM(fail_elem4),
        .AD(ad4), .DI(di4), .BEN(ben4), .EN(en4), .R_WB(r_wb4), .DO(dout4)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model with optional fault injection.
    always @(posedge clk) begin
        if (en) begin
            if (r_wb) begin
                dout <= mem[ad] | (((fault_mode == 2'd1) && (ad == 10'h2A5)) ? 32'h0000_0020 : 32'h0);
            end else begin
                mem[ad] <= di;
                if ((fault_mode == 2'd2) && (ad == 10'h001) && (di == 32'hFFFF_FFFF))
                    mem[0] <= 32'hFFFF_FFFF;
            end
        end
    end

    // Fault-free SRAM for the four-word instance.
    always @(posedge clk) begin
        if (en4) begin
            if (r_wb4) dout4 <= mem4[ad4];
            else       mem4[ad4] <= di4;
        end
    end

    task automatic start_test();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs the large instance until DONE; cycle 1 is the first access cycle.
    task automatic run_to_done(input int bound, input bit poke,
                               output int busy_n, output int en_n, output int last_en,
                               output int bus_bad, output bit timeout);
        busy_n = 0; en_n = 0; last_en = 0; bus_bad = 0; timeout = 1'b1;
        for (int c = 1; c <= bound; c++) begin
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) busy_n++;
            if (en) begin
                en_n++;
                last_en = c;
                if (ben !== 32'hFFFF_FFFF) bus_bad++;
            end else if (ad !== 10'h0 || di !== 32'h0 || ben !== 32'h0 || r_wb !== 1'b1) begin
                bus_bad++;
            end
            start = poke && (c == 100 || c == 5000);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({busy, done, fail, en, r_wb} !== 5'b00001) begin
            bad++; $display("FAIL reset_flags got=%b want=00001", {busy, done, fail, en, r_wb});
        end
        total++;
        if ({fail_addr, fail_elem} !== 13'h0) begin
            bad++; $display("FAIL reset_fail_info got=%h want=0", {fail_addr, fail_elem});
        end
        total++;
        if ({ad, di, ben} !== 74'h0) begin
            bad++; $display("FAIL reset_bus got ad=%h di=%h ben=%h want 0", ad, di, ben);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, en, busy4, en4} !== 5'b0) begin
            bad++; $display("FAIL idle_after_reset got=%b want=00000", {busy, done, en, busy4, en4});
        end
    endtask

    task automatic test_clean_run();
        int b, e, l, bb; bit to;
        fault_mode = 2'd0;
        start_test();
        run_to_done(20000, 1'b0, b, e, l, bb, to);
        total++;
        if (to !== 1'b0 || b != 10241 || e != 10240 || l != 10240) begin
            bad++; $display("FAIL clean_timing got to=%0d busy=%0d en=%0d last=%0d want 0/10241/10240/10240", to, b, e, l);
        end
        total++;
        if (bb != 0) begin
            bad++; $display("FAIL clean_bus got bad_cycles=%0d want 0", bb);
        end
        total++;
        if ({done, fail, busy, en} !== 4'b1000) begin
            bad++; $display("FAIL clean_result got=%b want=1000", {done, fail, busy, en});
        end
    endtask

    task automatic test_trace4();
        int k, n, nb, a;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            ex_rw[k] = 1'b0; ex_ad[k] = 2'(i); ex_di[k] = 32'h0; k++;
        end
        for (int e = 1; e <= 4; e++) begin
            for (int j = 0; j < 4; j++) begin
                a = (e >= 3) ? 3 - j : j;
                ex_rw[k] = 1'b1; ex_ad[k] = 2'(a); ex_di[k] = 32'h0; k++;
                ex_rw[k] = 1'b0; ex_ad[k] = 2'(a);
                ex_di[k] = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0; k++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            ex_rw[k] = 1'b1; ex_ad[k] = 2'(i); ex_di[k] = 32'h0; k++;
        end

        n = 0; nb = 0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done4) break;
            if (busy4) nb++;
            if (en4 && n < 64) begin
                tr_rw[n] = r_wb4; tr_ad[n] = ad4; tr_di[n] = di4; n++;
            end
            @(negedge clk);
        end
        total++;
        if (n != 40 || nb != 41) begin
            bad++; $display("FAIL trace4_count got accesses=%0d busy=%0d want 40/41", n, nb);
        end
        for (int i = 0; i < 40; i++) begin
            if (i < n) begin
                total++;
                if (tr_rw[i] !== ex_rw[i] || tr_ad[i] !== ex_ad[i] ||
                    (!ex_rw[i] && tr_di[i] !== ex_di[i])) begin
                    bad++;
                    $display("FAIL trace4_entry%0d got rw=%b ad=%0d di=%h want rw=%b ad=%0d di=%h",
                             i, tr_rw[i], tr_ad[i], tr_di[i], ex_rw[i], ex_ad[i], ex_di[i]);
                end
            end
        end
        total++;
        if ({done4, fail4, en4} !== 3'b100) begin
            bad++; $display("FAIL trace4_result got=%b want=100", {done4, fail4, en4});
        end
    endtask

    task automatic test_stuck_at();
        int b, e, l, bb, idle_bad; bit to;
        fault_mode = 2'd1;
        start_test();
        run_to_done(20000, 1'b0, b, e, l, bb, to);
        total++;
        if (to !== 1'b0 || {fail, fail_addr, fail_elem} !== {1'b1, 10'h2A5, 3'd1}) begin
            bad++; $display("FAIL stuck_report got to=%0d flag=%b addr=%h elem=%0d want 0/1/2a5/1", to, fail, fail_addr, fail_elem);
        end
        total++;
        if (b != 2380 || l < 2379 || l > 2380) begin
            bad++; $display("FAIL stuck_abort_timing got busy=%0d last_en=%0d want 2380/2379..2380", b, l);
        end
        idle_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) idle_bad++;
            @(negedge clk);
        end
        total++;
        if (idle_bad != 0) begin
            bad++; $display("FAIL stuck_end_hold got bad_cycles=%0d want 0", idle_bad);
        end
    endtask

    task automatic test_coupling();
        int b, e, l, bb; bit to;
        fault_mode = 2'd2;
        start_test();
        run_to_done(20000, 1'b0, b, e, l, bb, to);
        total++;
        if (to !== 1'b0 || {fail, fail_addr, fail_elem} !== {1'b1, 10'h000, 3'd3}) begin
            bad++; $display("FAIL coupling_report got to=%0d flag=%b addr=%h elem=%0d want 0/1/000/3", to, fail, fail_addr, fail_elem);
        end
        total++;
        if (b != 7168) begin
            bad++; $display("FAIL coupling_timing got busy=%0d want 7168", b);
        end
    endtask

    task automatic test_restart_with_pokes();
        int b, e, l, bb; bit to;
        fault_mode = 2'd0;
        start_test();
        total++;
        if ({busy, done, fail, fail_addr, fail_elem} !== {1'b1, 1'b0, 1'b0, 10'h0, 3'd0}) begin
            bad++; $display("FAIL restart_clear got busy=%b done=%b flag=%b addr=%h elem=%0d want 1/0/0/0/0", busy, done, fail, fail_addr, fail_elem);
        end
        run_to_done(20000, 1'b1, b, e, l, bb, to);
        total++;
        if (to !== 1'b0 || b != 10241 || e != 10240 || fail !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL restart_run got to=%0d busy=%0d en=%0d flag=%b done=%b want 0/10241/10240/0/1", to, b, e, fail, done);
        end
    endtask

    task automatic test_rst_mid();
        int b, e, l, bb; bit to;
        start_test();
        repeat (499) @(negedge clk);
        total++;
        if (busy !== 1'b1 || en !== 1'b1) begin
            bad++; $display("FAIL midrun_active got busy=%b en=%b want 1/1", busy, en);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, fail, en, r_wb, fail_addr, fail_elem, ad, di, ben} !==
            {5'b00001, 13'h0, 74'h0}) begin
            bad++; $display("FAIL midrun_reset got busy=%b done=%b flag=%b en=%b rwb=%b ad=%h di=%h ben=%h", busy, done, fail, en, r_wb, ad, di, ben);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, en, done} !== 3'b000) begin
            bad++; $display("FAIL reset_priority got busy=%b en=%b done=%b want 000", busy, en, done);
        end
        start_test();
        run_to_done(20000, 1'b0, b, e, l, bb, to);
        total++;
        if (to !== 1'b0 || b != 10241 || e != 10240 || fail !== 1'b0 || done !== 1'b1 || bb != 0) begin
            bad++; $display("FAIL post_reset_run got to=%0d busy=%0d en=%0d flag=%b done=%b busbad=%0d", to, b, e, fail, done, bb);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start4     = 1'b0;
        fault_mode = 2'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_clean_run();
        test_trace4();
        test_stuck_at();
        test_coupling();
        test_restart_with_pokes();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ef_sram_1024x32_bist.md
EF_SRAM_1024X32_BIST -- requirements
Module: EF_SRAM_1024x32_bist

Interface
REQ-001 Parameters SHALL be: NB, default 32, data bits; NA, default 10, address bits; NW, default 1024, words tested (addresses 0..NW-1).
REQ-002 CLKin  input  1  clock; all logic on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 START  input  1  one-cycle pulse; begins a March C- test.
REQ-005 BUSY  output  1  high while the test is in progress.
REQ-006 DONE  output  1  high once the test ends; held until the next accepted START or RST.
REQ-007 FAIL  output  1  high when a read mismatch was found; valid while DONE=1.
REQ-008 FAIL_ADDR  output  NA  address of the first mismatching read.
REQ-009 FAIL_ELEM  output  3  March element index (0..5) of the first mismatch.
REQ-010 AD  output  NA  SRAM address.
REQ-011 DI  output  NB  SRAM write data.
REQ-012 BEN  output  NB  SRAM bit enables; all ones on every access.
REQ-013 EN  output  1  SRAM access enable.
REQ-014 R_WB  output  1  SRAM direction; 1 = read, 0 = write.
REQ-015 DO  input  NB  SRAM read data.

Function
REQ-016 The block SHALL issue at most one SRAM access per cycle: EN=1 with AD, DI, R_WB valid in that cycle; the SRAM samples on the next rising CLKin.
REQ-017 Read data for an access issued in cycle t SHALL be compared against the expected value in cycle t+1.
REQ-018 The March sequence SHALL be: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-019 Background 0 SHALL be all zeros; background 1 SHALL be all ones (NB bits).
REQ-020 Up order SHALL be 0..NW-1; down order SHALL be NW-1..0.
REQ-021 Within E1-E4, the read and the write to one address SHALL occupy consecutive cycles, and the next address SHALL follow without idle cycles.
REQ-022 States SHALL be: IDLE, RUN, DRAIN, END.
REQ-023 Transition IDLE->RUN SHALL occur on START=1; the first access (E0, write to AD=0) SHALL be issued in the cycle after START is sampled.
REQ-024 Transition RUN->DRAIN SHALL occur after the E5 read of NW-1 is issued; DRAIN SHALL issue no access and SHALL perform the final compare.
REQ-025 Transition DRAIN->END SHALL occur unconditionally.
REQ-026 With no failure, the test SHALL take 10*NW access cycles plus 1 DRAIN cycle; DONE SHALL rise in the cycle after DRAIN.
REQ-027 On the first mismatch, the block SHALL set FAIL=1, latch FAIL_ADDR and FAIL_ELEM from the compared read, and abort to END.
REQ-028 After an abort, EN SHALL be 0 from the next cycle onward; an access issued in the compare cycle itself is permitted.
REQ-029 In END, DONE SHALL be 1, BUSY 0, and EN 0; a START in END SHALL restart the test and clear FAIL, FAIL_ADDR, FAIL_ELEM, and DONE.
REQ-030 START while BUSY=1 SHALL be ignored.
REQ-031 BUSY SHALL be 1 in RUN and DRAIN only.
REQ-032 When EN=0, the SRAM outputs SHALL be: AD=0, DI=0, BEN=0, R_WB=1.
REQ-033 Address counters SHALL be NA bits wide and SHALL never wrap past 0 or NW-1 within an element.

Reset
REQ-034 RST=1 SHALL force IDLE with BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, FAIL_ELEM=0, EN=0, AD=0, DI=0, BEN=0, R_WB=1.
REQ-035 RST asserted mid-test SHALL abort the test with no further SRAM access from the next cycle; RST SHALL take priority over START.

Verification
REQ-036 NW=1024, fault-free SRAM model, START pulse -> BUSY for 10241 cycles, then DONE=1, FAIL=0; total EN cycles 10240.
REQ-037 NW=4, access trace -> exactly: W0 0-3; (R0,W1) 0-3; (R1,W0) 0-3; (R0,W1) 3-0; (R1,W0) 3-0; R0 0-3.
REQ-038 Stuck-at-1 on bit 5 of address 0x2A5 -> FAIL=1, FAIL_ADDR=0x2A5, FAIL_ELEM=1; EN=0 from the cycle after the compare.
REQ-039 Coupling fault: writing 1 to 0x001 flips 0x000 to 1 -> FAIL=1, FAIL_ELEM=3, FAIL_ADDR=0x000.
REQ-040 RST pulsed at cycle 500 of a test, then START -> all outputs at reset values, then a full clean run with DONE=1, FAIL=0.
REQ-041 START pulses during BUSY, then START in END after a failure -> mid-test pulses ignored with no change in timing; the restart clears FAIL and the run completes.
